chardisp_axi_slave: RTL
=======================

// Module: chardisp_axi_slave
// PURPOSE
// - AXI4-Lite slave front end for the character display.
// - Converts AXI4-Lite write/read transactions into the single-cycle VRAM strobe bus (WRADDR/BYTEEN/WREN/WRDATA, RDADDR/RDEN/RDDATA).
// - Sits between the PS interconnect and chardisp.
// - Allows one transaction outstanding at a time; WREN and RDEN are never asserted together, because the shared VRAM port A address is muxed by RDEN.
// PARAMETERS
// - ADDR_W      16    AXI address width; byte address, word index = ADDR[ADDR_W-1:2]
// - RD_LATENCY  1     cycles from an RDEN pulse to valid RDDATA (1..4)
// - VRAM_WORDS  4096  number of implemented 32-bit words, used by the range check
// PORTS
// - CLK      in   1       system clock (AXI ACLK)
// - RST      in   1       asynchronous active-high reset
// - AWADDR   in   ADDR_W  write address
// - AWVALID  in   1       write address valid
// - AWREADY  out  1       write address ready
// - WDATA    in   32      write data
// - WSTRB    in   4       write byte strobes
// - WVALID   in   1       write data valid
// - WREADY   out  1       write data ready
// - BRESP    out  2       write response: 00 OKAY, 10 SLVERR
// - BVALID   out  1       write response valid
// - BREADY   in   1       write response ready
// - ARADDR   in   ADDR_W  read address
// - ARVALID  in   1       read address valid
// - ARREADY  out  1       read address ready
// - RDATA    out  32      read data
// - RRESP    out  2       read response
// - RVALID   out  1       read data valid
// - RREADY   in   1       read data ready
// - WRADDR   out  ADDR_W  registered write byte address to chardisp
// - BYTEEN   out  4       registered byte enables
// - WREN     out  1       one-cycle write strobe
// - WRDATA   out  32      registered write data
// - RDADDR   out  ADDR_W  registered read byte address
// - RDEN     out  1       one-cycle read strobe
// - RDDATA   in   32      read data from chardisp; valid RD_LATENCY cycles after RDEN
// BEHAVIOUR
// - Reset values:
//   - All outputs are 0, FSM is in IDLE, and the arbitration pointer favours reads.
//   - On reset mid-transaction, the transaction is dropped with no strobe and no response.
//   - A handshake completed in the cycle before reset never produces WREN or RDEN.
// - FSM states: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
// - IDLE, write acceptance:
//   - A write is accepted only when AWVALID and WVALID are both high.
//   - AWREADY and WREADY are pulsed together for one cycle (the handshake cycle).
//   - AWADDR, WDATA and WSTRB are latched in that cycle.
//   - Next state is WR_ISSUE.
// - IDLE, read acceptance:
//   - When ARVALID is high, ARREADY is pulsed for one cycle and ARADDR is latched.
//   - Next state is RD_ISSUE.
// - Arbitration when the write and read requests are both pending in IDLE:
//   - Grant the side the pointer favours; the pointer then flips to the other side.
//   - The pointer is unchanged when only one side requests.
// - WR_ISSUE: WREN=1 for exactly one cycle with WRADDR/BYTEEN/WRDATA stable; next state is WR_RESP.
// - WR_RESP: BVALID=1, held with BRESP until BREADY; IDLE on the BVALID&BREADY cycle.
// - RD_ISSUE: RDEN=1 for exactly one cycle; next state is RD_WAIT.
// - RD_WAIT: counts RD_LATENCY-1 further cycles; RDATA<=RDDATA is captured at the end of the last one; next state is RD_RESP.
// - RD_RESP: RVALID=1 with RDATA/RRESP stable until RREADY; IDLE on the RVALID&RREADY cycle.
// - Latency:
//   - Write: handshake = cycle 0, WREN in cycle 1, BVALID from cycle 2.
//   - Read: handshake = cycle 0, RDEN in cycle 1, RVALID from cycle 2+RD_LATENCY.
// - No AWREADY, WREADY or ARREADY outside IDLE; the next handshake can be no earlier than the cycle after the B or R handshake.
// - A lone AWVALID or lone WVALID waits in IDLE; a pending read is still served meanwhile.
// - WRADDR/RDADDR/BYTEEN/WRDATA hold their last values between strobes.
// - Addresses pass through unmodified; chardisp uses bits [13:2].
// CONFIGURATION
// - CHARDISP_AXI_SLVERR_EN defined:
//   - A word index >= VRAM_WORDS suppresses the WREN/RDEN strobe (the FSM still passes through ISSUE/WAIT states, so latency is unchanged).
//   - BRESP/RRESP=2'b10 and RDATA=32'h0 for such accesses.
// - CHARDISP_AXI_SLVERR_EN undefined:
//   - No range check; every response is OKAY and the VRAM address wraps naturally.
// TESTING
// - Write AW=0x0010, W=0x00ABCDEF, WSTRB=0x7 with both valid -> WREN 1 cycle at cycle 1, WRADDR=0x0010, BYTEEN=0x7; BVALID at cycle 2, BRESP=00.
// - Read AR=0x0010, RDDATA model returning 0x00ABCDEF with RD_LATENCY=1 -> RDEN at cycle 1, RVALID at cycle 3, RDATA=0x00ABCDEF.
// - AWVALID/WVALID/ARVALID all high for 4 back-to-back transactions -> grants alternate R,W,R,W; WREN&RDEN never both 1.
// - BREADY held low 10 cycles -> BVALID stays 1, AWREADY/ARREADY stay 0, and no strobe occurs until BREADY.
// - RST asserted in cycle 1 of a write -> WREN not asserted, BVALID=0, and the FSM returns to IDLE.
// - With CHARDISP_AXI_SLVERR_EN and VRAM_WORDS=4000, write to 0x3E80 -> no WREN, BRESP=10; without the macro -> WREN=1, BRESP=00.

Source files
------------

// File: rtl/chardisp_axi_slave.sv
// chardisp_axi_slave
//   AXI4-Lite slave front end for the character display. Each AXI write or
//   read becomes a one-cycle strobe on the VRAM bus (WREN or RDEN). Only one
//   transaction is in flight at a time, so WREN and RDEN are never high
//   together. This matters because RDEN muxes the shared VRAM port-A address.
//
// Optional feature (macro CHARDISP_AXI_SLVERR_EN):
//   When the macro is defined, an access whose word index is >= VRAM_WORDS
//   has its strobe suppressed and is answered with SLVERR, with RDATA = 0.
//   When the macro is undefined, every access is OKAY and the address wraps.
//
// Ports:
//   CLK, RST                    clock, asynchronous active-high reset
//   AW*/W*/B*                   AXI4-Lite write address/data/response
//   AR*/R*                      AXI4-Lite read address/data
//   WRADDR/BYTEEN/WRDATA/WREN   registered VRAM write strobe bus
//   RDADDR/RDEN                 registered VRAM read strobe bus
//   RDDATA                      VRAM read data, valid RD_LATENCY cycles after RDEN
module chardisp_axi_slave #(
  parameter int ADDR_W     = 16,
  parameter int RD_LATENCY = 1,
  parameter int VRAM_WORDS = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [ADDR_W-1:0] WRADDR,
  output logic [3:0]        BYTEEN,
  output logic              WREN,
  output logic [31:0]       WRDATA,
  output logic [ADDR_W-1:0] RDADDR,
  output logic              RDEN,
  input  logic [31:0]       RDDATA
);

`ifdef CHARDISP_AXI_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif

  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_RESP  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RD_RESP  = 3'd5
  } state_t;

  state_t     state, state_next;
  logic       prefer_rd;
  logic [1:0] wait_cnt;
  logic       wr_err, rd_err;
  logic       wr_req, rd_req;
  logic       grant_wr, grant_rd;
  logic       aw_bad, ar_bad;

  // Word index lies outside the implemented VRAM.
  function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
    logic [31:0] idx;
    idx = 32'(addr >> 2);
    return idx >= 32'(VRAM_WORDS);
  endfunction

  assign wr_req  = AWVALID & WVALID;
  assign rd_req  = ARVALID;
  assign aw_bad  = SLVERR_EN & out_of_range(AWADDR);
  assign ar_bad  = SLVERR_EN & out_of_range(ARADDR);

  // Ready pulses must coincide with the valid they answer, so they come straight from the grant.
  assign AWREADY = grant_wr;
  assign WREADY  = grant_wr;
  assign ARREADY = grant_rd;

  // Next-state logic and IDLE arbitration; grants are held off while reset is asserted.
  always_comb begin
    state_next = state;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (RST) begin
          state_next = IDLE;
        end else if (rd_req && (!wr_req || prefer_rd)) begin
          grant_rd   = 1'b1;
          state_next = RD_ISSUE;
        end else if (wr_req) begin
          grant_wr   = 1'b1;
          state_next = WR_ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      WR_ISSUE: state_next = WR_RESP;
      WR_RESP: begin
        if (BREADY) state_next = IDLE;
        else        state_next = WR_RESP;
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_next = RD_RESP;
        else                       state_next = RD_WAIT;
      end
      RD_RESP: begin
        if (RREADY) state_next = IDLE;
        else        state_next = RD_RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and arbitration pointer; the pointer flips only on a contested grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      prefer_rd <= 1'b1;
    end else begin
      state <= state_next;
      if ((grant_wr || grant_rd) && wr_req && rd_req) prefer_rd <= ~prefer_rd;
    end
  end

  // Read-latency counter, counting from zero on entry to RD_WAIT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                  wait_cnt <= 2'd0;
    else if (state == RD_WAIT) wait_cnt <= wait_cnt + 2'd1;
    else                      wait_cnt <= 2'd0;
  end

  // Write path: latch on the handshake, strobe in the following cycle, respond after that.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WRADDR <= '0;
      WRDATA <= 32'h0;
      BYTEEN <= 4'h0;
      wr_err <= 1'b0;
      WREN   <= 1'b0;
      BVALID <= 1'b0;
      BRESP  <= 2'b00;
    end else begin
      if (grant_wr) begin
        WRADDR <= AWADDR;
        WRDATA <= WDATA;
        BYTEEN <= WSTRB;
        wr_err <= aw_bad;
      end
      WREN   <= grant_wr & ~aw_bad;
      BVALID <= (state_next == WR_RESP);
      BRESP  <= ((state_next == WR_RESP) && wr_err) ? 2'b10 : 2'b00;
    end
  end

  // Read path: latch on the handshake, strobe, capture RDDATA at the end of RD_WAIT, respond.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RDADDR <= '0;
      rd_err <= 1'b0;
      RDEN   <= 1'b0;
      RDATA  <= 32'h0;
      RVALID <= 1'b0;
      RRESP  <= 2'b00;
    end else begin
      if (grant_rd) begin
        RDADDR <= ARADDR;
        rd_err <= ar_bad;
      end
      RDEN <= grant_rd & ~ar_bad;
      if ((state == RD_WAIT) && (wait_cnt == WAIT_LAST)) begin
        RDATA <= rd_err ? 32'h0 : RDDATA;
      end
      RVALID <= (state_next == RD_RESP);
      RRESP  <= ((state_next == RD_RESP) && rd_err) ? 2'b10 : 2'b00;
    end
  end

endmodule
